// File: rtl/det_rr_sched_pkg.sv
// Shared encodings and detector next-state helper for the round-robin
// "1-1-0" detector scheduler.
package det_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    D_S0  = 2'd0,
    D_S1  = 2'd1,
    D_S11 = 2'd2
  } det_state_t;

  // Trailing 1s keep the detector in S11 so overlapping patterns are caught.
  function automatic det_state_t det_next(input det_state_t cur, input logic din);
    case (cur)
      D_S0:    det_next = din ? D_S1  : D_S0;
      D_S1:    det_next = din ? D_S11 : D_S0;
      D_S11:   det_next = din ? D_S11 : D_S0;
      default: det_next = D_S0;
    endcase
  endfunction

endpackage

// File: rtl/det_rr_sched_det_core.sv
// Bit-serial "1-1-0" sequence detector; hit is combinational with the
// consumed bit so the caller can count it in the same cycle.
module det_core
  import det_rr_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic vld,
  input  logic din,
  output logic hit
);

  det_state_t state_r;

  assign hit = vld & (state_r == D_S11) & ~din;

  // Detector state: cleared between frames, advanced on each consumed bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= D_S0;
    end else if (clr) begin
      state_r <= D_S0;
    end else if (vld) begin
      state_r <= det_next(state_r, din);
    end
  end

endmodule

// File: rtl/det_rr_sched.sv
// Round-robin scheduler sharing one "1-1-0" detector among NREQ serial
// requesters; reports per-frame hit counts with the requester ID.
module det_rr_sched
  import det_rr_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5,
  parameter int ID_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  bit_in,
  input  logic [NREQ-1:0]  bit_vld,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               BC_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_LEN - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [ID_W-1:0]  ptr_r;
  logic [ID_W-1:0]  win_r;
  logic [BC_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0] hit_cnt_r;

  logic [ID_W-1:0]  pick_s;
  logic             run_s;
  logic             abort_s;
  logic             take_s;
  logic             last_s;
  logic             clr_s;
  logic             hit_s;
  logic [CNT_W-1:0] hit_next_s;
  logic [ID_W-1:0]  nxt_ptr_s;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    return ID_W'((int'(base) + off) % NREQ);
  endfunction

  // Winner search: scanning downward lets the lowest offset from ptr win.
  always_comb begin
    pick_s = {ID_W{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      pick_s = req[rr_idx(ptr_r, i)] ? rr_idx(ptr_r, i) : pick_s;
    end
  end

  // Per-cycle frame control; abort masks consumption so it wins over frame end.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    abort_s    = run_s & ~req[win_r];
    take_s     = run_s & ~abort_s & bit_vld[win_r];
    last_s     = take_s & (bit_cnt_r == LAST_BIT);
    clr_s      = ~run_s;
    hit_next_s = (hit_s && (hit_cnt_r != CNT_MAX)) ? hit_cnt_r + CNT_W'(1) : hit_cnt_r;
    nxt_ptr_s  = (win_r == LAST_ID) ? {ID_W{1'b0}} : win_r + ID_W'(1);
  end

  det_core u_det_core (
    .clk (clk),
    .rst (rst),
    .clr (clr_s),
    .vld (take_s),
    .din (bit_in[win_r]),
    .hit (hit_s)
  );

  // Scheduler FSM with registered grant, status and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {ID_W{1'b0}};
      win_r     <= {ID_W{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
      hit_cnt_r <= {CNT_W{1'b0}};
      gnt       <= {NREQ{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= {ID_W{1'b0}};
      match_cnt <= {CNT_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= ONE_HOT0 << pick_s;
            win_r     <= pick_s;
            busy      <= 1'b1;
            bit_cnt_r <= {BC_W{1'b0}};
            hit_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            gnt     <= {NREQ{1'b0}};
            busy    <= 1'b0;
            ptr_r   <= nxt_ptr_s;
            state_r <= ST_IDLE;
          end else if (take_s) begin
            bit_cnt_r <= bit_cnt_r + BC_W'(1);
            hit_cnt_r <= hit_next_s;
            if (last_s) begin
              gnt       <= {NREQ{1'b0}};
              done      <= 1'b1;
              done_id   <= win_r;
              match_cnt <= hit_next_s;
              ptr_r     <= nxt_ptr_s;
              state_r   <= ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
